// File: rtl/serial_adder.sv
// Bit-serial WIDTH-bit adder: one full-adder cell plus a carry flop, LSB first.
// Operands are captured on an accepted start; sum/cout update only at completion.
module serial_adder #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             cout
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  // One-hot-style encoding so busy/done come straight from state flops.
  typedef enum logic [1:0] {
    IDLE = 2'b00,
    RUN  = 2'b01,
    DONE = 2'b10
  } state_t;

  state_t           state;
  state_t           state_nxt;

  logic [WIDTH-1:0] a_sr;
  logic [WIDTH-1:0] b_sr;
  logic [WIDTH-1:0] sum_sr;
  logic             carry;
  logic [CW-1:0]    cnt;

  logic             accept;
  logic             last_bit;
  logic             bit_sum;
  logic             bit_carry;
  logic [WIDTH:0]   sum_cat;
  logic [WIDTH-1:0] sum_sr_nxt;

  assign accept    = (state == IDLE) && start;
  assign last_bit  = (cnt == CW'(WIDTH - 1));
  assign bit_sum   = a_sr[0] ^ b_sr[0] ^ carry;
  assign bit_carry = (a_sr[0] & b_sr[0]) | (a_sr[0] & carry) | (b_sr[0] & carry);

  // The new bit enters at the MSB; the concatenation keeps WIDTH=1 legal.
  assign sum_cat    = {bit_sum, sum_sr};
  assign sum_sr_nxt = sum_cat[WIDTH:1];

  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // pre-edge values, independent of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // NOTE: defaulting state_nxt first guarantees no latch on any path.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (accept)   state_nxt = RUN;
      RUN:     if (last_bit) state_nxt = DONE;
      DONE:                  state_nxt = IDLE;
      default:               state_nxt = IDLE;
    endcase
  end

  always_comb begin
    busy = state[0];
    done = state[1];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_sr   <= '0;
      b_sr   <= '0;
      sum_sr <= '0;
      carry  <= 1'b0;
      cnt    <= '0;
      sum    <= '0;
      cout   <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (accept) begin
            a_sr  <= a;
            b_sr  <= b;
            carry <= cin;
            cnt   <= '0;
          end
        end
        RUN: begin
          a_sr   <= a_sr >> 1;
          b_sr   <= b_sr >> 1;
          carry  <= bit_carry;
          sum_sr <= sum_sr_nxt;
          cnt    <= cnt + 1'b1;
          // Publish the result on the edge that folds in the last bit.
          if (last_bit) begin
            sum  <= sum_sr_nxt;
            cout <= bit_carry;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_serial_adder.sv
// Directed bench for serial_adder (WIDTH=8 and WIDTH=1) with a result scoreboard.
module tb_serial_adder;

  logic       clk = 1'b0;
  logic       rst_n;

  logic       start8, cin8, busy8, done8, cout8;
  logic [7:0] a8, b8, sum8;

  logic       start1, a1, b1, cin1, busy1, done1, sum1, cout1;

  int n_tests = 0;
  int n_fail  = 0;

  logic [8:0] q8[$];
  logic [1:0] q1[$];

  always #5 clk = ~clk;

  serial_adder #(.WIDTH(8)) dut8 (
    .clk(clk), .rst_n(rst_n), .start(start8), .a(a8), .b(b8), .cin(cin8),
    .busy(busy8), .done(done8), .sum(sum8), .cout(cout8)
  );

  serial_adder #(.WIDTH(1)) dut1 (
    .clk(clk), .rst_n(rst_n), .start(start1), .a(a1), .b(b1), .cin(cin1),
    .busy(busy1), .done(done1), .sum(sum1), .cout(cout1)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // One WIDTH=8 operation; with junk set, start and operands are disturbed mid-RUN.
  task automatic op8(input logic [7:0] a, input logic [7:0] b, input logic c, input bit junk);
    int         cyc;
    logic [8:0] e;
    @(negedge clk);
    a8 = a; b8 = b; cin8 = c; start8 = 1'b1;
    q8.push_back({1'b0, a} + {1'b0, b} + 9'(c));
    @(negedge clk);
    if (junk) begin
      start8 = 1'b1; a8 = 8'hAA; b8 = 8'h55; cin8 = 1'b1;
    end else begin
      start8 = 1'b0;
    end
    cyc = 0;
    while (done8 !== 1'b1 && cyc <= 32) begin
      chk("busy8_run", busy8, 1);
      chk("done8_early", done8, 0);
      if (cyc == 4) start8 = 1'b0;
      @(negedge clk);
      cyc++;
    end
    start8 = 1'b0;
    chk("done8_latency", cyc, 8);
    chk("busy8_at_done", busy8, 0);
    if (q8.size() > 0) begin
      e = q8.pop_front();
      chk("sum8_cout8", {cout8, sum8}, e);
    end
    @(negedge clk);
    chk("done8_one_cycle", done8, 0);
    chk("busy8_after_done", busy8, 0);
    chk("sum8_holds", {cout8, sum8}, e);
  endtask

  task automatic op1(input logic a, input logic b, input logic c);
    logic [1:0] e;
    @(negedge clk);
    a1 = a; b1 = b; cin1 = c; start1 = 1'b1;
    q1.push_back(2'(a) + 2'(b) + 2'(c));
    @(negedge clk);
    start1 = 1'b0;
    chk("busy1_run", busy1, 1);
    chk("done1_early", done1, 0);
    @(negedge clk);
    chk("done1_latency", done1, 1);
    chk("busy1_at_done", busy1, 0);
    if (q1.size() > 0) begin
      e = q1.pop_front();
      chk("sum1_cout1", {cout1, sum1}, e);
    end
    @(negedge clk);
    chk("done1_one_cycle", done1, 0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int         cyc;
    int         last;
    int         pulses;
    logic [8:0] e;

    rst_n  = 1'b0;
    start8 = 1'b0; a8 = '0; b8 = '0; cin8 = 1'b0;
    start1 = 1'b0; a1 = 1'b0; b1 = 1'b0; cin1 = 1'b0;
    repeat (2) @(negedge clk);
    chk("reset8_outputs", {busy8, done8, cout8, sum8}, 0);
    chk("reset1_outputs", {busy1, done1, cout1, sum1}, 0);
    rst_n = 1'b1;

    // Basic additions, wrap and all-ones with carry-in.
    op8(8'h3C, 8'h5A, 1'b0, 1'b0);
    op8(8'hFF, 8'h01, 1'b0, 1'b0);
    op8(8'hFF, 8'hFF, 1'b1, 1'b0);

    // start and operand changes during RUN must be ignored.
    op8(8'h10, 8'h20, 1'b0, 1'b1);
    repeat (3) begin
      @(negedge clk);
      chk("no_extra_done", done8, 0);
    end

    // start held high: back-to-back operations every WIDTH+2 cycles.
    @(negedge clk);
    a8 = 8'h07; b8 = 8'h09; cin8 = 1'b0; start8 = 1'b1;
    repeat (3) q8.push_back(9'h007 + 9'h009);
    cyc = -1; last = -1; pulses = 0;
    for (int i = 0; i < 30; i++) begin
      @(negedge clk);
      cyc++;
      if (done8 === 1'b1) begin
        pulses++;
        chk("hold_busy_at_done", busy8, 0);
        if (q8.size() > 0) begin
          e = q8.pop_front();
          chk("hold_sum", {cout8, sum8}, e);
        end
        if (last >= 0) chk("hold_spacing", cyc - last, 10);
        last = cyc;
      end else if (last >= 0 && cyc == last + 1) begin
        chk("hold_busy_idle", busy8, 0);
      end
    end
    start8 = 1'b0;
    chk("hold_pulses", pulses, 3);

    // Asynchronous reset mid-RUN aborts and clears outputs at once.
    @(negedge clk);
    a8 = 8'h80; b8 = 8'h80; cin8 = 1'b0; start8 = 1'b1;
    @(negedge clk);
    start8 = 1'b0;
    repeat (3) @(negedge clk);
    #2 rst_n = 1'b0;
    #1 chk("async_reset_outputs", {busy8, done8, cout8, sum8}, 0);
    repeat (2) @(negedge clk);
    chk("reset_no_done", done8, 0);
    rst_n = 1'b1;
    op8(8'h01, 8'h02, 1'b0, 1'b0);

    // WIDTH=1 instance.
    op1(1'b1, 1'b1, 1'b1);
    op1(1'b0, 1'b0, 1'b0);

    chk("scoreboard8_empty", q8.size(), 0);
    chk("scoreboard1_empty", q1.size(), 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/serial_adder.md
Name: serial_adder

Overview:
- Bit-serial N-bit adder: the additive counterpart to the team's subtractor primitives.
- Captures two operands and a carry-in on a start request.
- Computes one bit per clock, LSB first, through a single full-adder cell and a carry flop.
- Reports the registered sum and carry-out with a one-cycle done pulse. Used where area matters more than latency, e.g. accumulator updates in slow control paths.

Parameters:
- WIDTH, 8, operand/sum width in bits; legal range WIDTH >= 1.

Ports:
- clk    input   1      rising-edge clock.
- rst_n  input   1      asynchronous active-low reset; the only clock and only reset.
- start  input   1      request; sampled only in IDLE.
- a      input   WIDTH  operand A; captured at accepted start.
- b      input   WIDTH  operand B; captured at accepted start.
- cin    input   1      carry-in; captured at accepted start.
- busy   output  1      high while bits are being computed (RUN).
- done   output  1      one-cycle pulse; sum/cout valid and updated this cycle.
- sum    output  WIDTH  registered result a+b+cin mod 2^WIDTH; holds until next completion.
- cout   output  1      registered carry-out of the MSB; holds with sum.

Behaviour:
- Reset (rst_n low, asynchronous):
  - state=IDLE; busy=0, done=0, sum=0, cout=0.
  - Internal shift registers, carry flop and bit counter cleared.
  - Takes effect immediately regardless of clk.
- States: IDLE, RUN, DONE. All outputs are registered; no combinational path from inputs to outputs.
- IDLE:
  - Edge E0 with start=1: load a, b into shift regs; carry flop <= cin; counter <= 0; state -> RUN; busy=1 after E0.
  - start=0: remain IDLE.
- RUN, each edge:
  - s = a_sr[0] ^ b_sr[0] ^ c; c <= majority(a_sr[0], b_sr[0], c).
  - Shift a_sr/b_sr right by 1; shift s into sum_sr MSB (right shift), so the LSB result lands at bit 0 after WIDTH shifts.
  - counter++.
- RUN completion:
  - The edge that processes bit WIDTH-1 is E_WIDTH.
  - At E_WIDTH: sum <= final sum_sr contents including that bit; cout <= final carry; done <= 1; busy <= 0; state -> DONE.
- DONE: next edge: done <= 0, state -> IDLE. start is ignored in this state.
- Latency and throughput:
  - done is high in the cycle following edge E_WIDTH, i.e. exactly WIDTH cycles after the start edge.
  - Minimum start-to-start spacing is WIDTH+2 cycles. With start held high continuously, a new op is accepted at E_WIDTH+2.
- start while busy or done: ignored; no restart, no queuing.
- a/b/cin changes after E0: ignored; the captured values are used.
- Counter width: max(1, clog2(WIDTH)). WIDTH=1: RUN lasts one edge, done is high 1 cycle after start.
- Reset mid-RUN: operation aborted, no done pulse, sum/cout forced to 0. The first start after reset release behaves normally.
- Overflow: the sum wraps modulo 2^WIDTH; cout carries bit WIDTH.
- sum/cout are never updated except at completion edges or reset.

Test Plan:
- WIDTH=8, a=8'h3C, b=8'h5A, cin=0, start pulse -> busy high 8 cycles; done 1 cycle, 8 cycles after start edge; sum=8'h96, cout=0.
- a=8'hFF, b=8'h01, cin=0 -> sum=8'h00, cout=1. Then a=8'hFF, b=8'hFF, cin=1 -> sum=8'hFF, cout=1.
- Start 8'h10+8'h20; mid-RUN drive start=1 and a=8'hAA, b=8'h55 -> ignored; result sum=8'h30, cout=0; exactly one done pulse.
- Start 8'h80+8'h80; assert rst_n low 3 cycles after start -> busy/done/sum/cout=0 immediately. After release, 8'h01+8'h02 gives sum=8'h03 at the expected cycle.
- start held high permanently with constant operands 8'h07+8'h09 -> done pulses repeat every 10 cycles; sum=8'h10 each time; busy low in the DONE and IDLE cycles.
- WIDTH=1 instance: a=1, b=1, cin=1 -> done 1 cycle after start; sum=1, cout=1. a=0, b=0, cin=0 -> sum=0, cout=0.
